photon_deadlock_monitor: RTL and testbench



---
 rtl/photon_dbg_pkg.sv | 25 ++
 rtl/photon_deadlock_group_eval.sv | 24 ++
 rtl/photon_deadlock_monitor.sv | 167 ++++++++++++++++
 tb/tb_photon_deadlock_monitor.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/photon_dbg_pkg.sv
// Shared debug-monitor types and helpers for photon dataflow regions.
package photon_dbg_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMING  = 2'd1,
        BLOCKED = 2'd2
    } mon_state_t;

    localparam int CNT_W_DEFAULT = 16;
    localparam int LSB_VEC_W     = 64;

    // Index of the lowest set bit of vec; returns n when no bit is set.
    function automatic int lowest_set_idx(input logic [LSB_VEC_W-1:0] vec, input int n);
        int idx;
        idx = n;
        for (int i = LSB_VEC_W - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/photon_deadlock_group_eval.sv
// Group deadlock term: every sub-instance idle or blocked, and at least one blocked.
module photon_deadlock_group_eval
    import photon_dbg_pkg::*;
#(
    parameter  int N_INST = 1,
    localparam int INST_W = (N_INST > 0) ? N_INST : 1
) (
    input  logic [INST_W-1:0] inst_idle_sigs,
    input  logic [INST_W-1:0] inst_block_sigs,
    output logic              group_hit
);

    generate
        if (N_INST > 0) begin : g_eval
            assign group_hit = (&(inst_idle_sigs | inst_block_sigs)) & (|inst_block_sigs);
        end else begin : g_none
            // Inputs are don't-care here; the term is a hard zero so X cannot leak.
            logic unused_inst_s;
            assign unused_inst_s = ^{inst_idle_sigs, inst_block_sigs};
            assign group_hit     = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/photon_deadlock_monitor.sv
// Deadlock monitor for one dataflow region: debounced block flag, sticky, source and event count.
// Optional build macro DEADLOCK_MON_TIMESTAMP_EN adds a cycle counter and the block_ts output.
module photon_deadlock_monitor
    import photon_dbg_pkg::*;
#(
    parameter  int N_AXIS      = 1,
    parameter  int N_INST      = 1,
    parameter  int HOLD_CYCLES = 1,
    parameter  int CNT_W       = CNT_W_DEFAULT,
    localparam int INST_W      = (N_INST > 0) ? N_INST : 1,
    localparam int SRC_W       = $clog2(N_AXIS + 1),
    localparam int RUN_W       = $clog2(HOLD_CYCLES + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [N_AXIS-1:0] axis_block_sigs,
    input  logic [INST_W-1:0] inst_idle_sigs,
    input  logic [INST_W-1:0] inst_block_sigs,
    input  logic              clear,
    output logic              block,
    output logic              block_sticky,
    output logic [SRC_W-1:0]  block_src,
    output logic [CNT_W-1:0]  block_events
`ifdef DEADLOCK_MON_TIMESTAMP_EN
    ,
    output logic [31:0]       block_ts
`endif
);

    localparam logic [RUN_W-1:0] HOLD_LAST = RUN_W'(HOLD_CYCLES - 1);

    mon_state_t         state_r, state_next_s;
    logic [RUN_W-1:0]   run_cnt_r, run_cnt_next_s;
    logic               axis_hit_s, group_hit_s, cond_s, entry_s;
    logic [LSB_VEC_W-1:0] axis_ext_s;
    logic [SRC_W-1:0]   src_sel_s;
    logic               block_r, sticky_r;
    logic [SRC_W-1:0]   src_r;
    logic [CNT_W-1:0]   events_r;

    photon_deadlock_group_eval #(.N_INST(N_INST)) u_group_eval (
        .inst_idle_sigs  (inst_idle_sigs),
        .inst_block_sigs (inst_block_sigs),
        .group_hit       (group_hit_s)
    );

    assign axis_hit_s = |axis_block_sigs;
    assign cond_s     = axis_hit_s | group_hit_s;
    assign axis_ext_s = LSB_VEC_W'(axis_block_sigs);
    // With no stream bit set the helper yields N_AXIS, which is the group source code.
    assign src_sel_s  = SRC_W'(lowest_set_idx(axis_ext_s, N_AXIS));
    assign entry_s    = (state_next_s == BLOCKED) && (state_r != BLOCKED);

    // Next-state and run-length logic for the persistence filter.
    always_comb begin
        state_next_s   = state_r;
        run_cnt_next_s = run_cnt_r;
        case (state_r)
            IDLE: begin
                if (cond_s) begin
                    if (HOLD_CYCLES == 1) begin
                        state_next_s = BLOCKED;
                    end else begin
                        state_next_s   = ARMING;
                        run_cnt_next_s = RUN_W'(1);
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            ARMING: begin
                if (!cond_s) begin
                    state_next_s   = IDLE;
                    run_cnt_next_s = {RUN_W{1'b0}};
                end else begin
                    run_cnt_next_s = run_cnt_r + RUN_W'(1);
                    if (run_cnt_r == HOLD_LAST) begin
                        state_next_s = BLOCKED;
                    end else begin
                        state_next_s = ARMING;
                    end
                end
            end
            BLOCKED: begin
                if (!cond_s) begin
                    state_next_s   = IDLE;
                    run_cnt_next_s = {RUN_W{1'b0}};
                end else begin
                    state_next_s = BLOCKED;
                end
            end
            default: begin
                state_next_s   = IDLE;
                run_cnt_next_s = {RUN_W{1'b0}};
            end
        endcase
    end

    // FSM state, run counter and live block flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r   <= IDLE;
            run_cnt_r <= {RUN_W{1'b0}};
            block_r   <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            run_cnt_r <= run_cnt_next_s;
            block_r   <= (state_next_s == BLOCKED);
        end
    end

    // Status capture; a BLOCKED entry overrides a coincident clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            sticky_r <= 1'b0;
            src_r    <= {SRC_W{1'b0}};
            events_r <= {CNT_W{1'b0}};
        end else if (entry_s) begin
            sticky_r <= 1'b1;
            src_r    <= src_sel_s;
            if (clear) begin
                events_r <= CNT_W'(1);
            end else if (events_r == {CNT_W{1'b1}}) begin
                events_r <= events_r;
            end else begin
                events_r <= events_r + CNT_W'(1);
            end
        end else if (clear) begin
            sticky_r <= 1'b0;
            src_r    <= {SRC_W{1'b0}};
            events_r <= {CNT_W{1'b0}};
        end else begin
            sticky_r <= sticky_r;
            src_r    <= src_r;
            events_r <= events_r;
        end
    end

    assign block        = block_r;
    assign block_sticky = sticky_r;
    assign block_src    = src_r;
    assign block_events = events_r;

`ifdef DEADLOCK_MON_TIMESTAMP_EN
    logic [31:0] cycle_cnt_r, ts_r;

    // Free-running cycle counter and entry timestamp capture.
    always_ff @(posedge clock) begin
        if (reset) begin
            cycle_cnt_r <= 32'd0;
            ts_r        <= 32'd0;
        end else begin
            cycle_cnt_r <= cycle_cnt_r + 32'd1;
            if (entry_s) begin
                ts_r <= cycle_cnt_r;
            end else if (clear) begin
                ts_r <= 32'd0;
            end else begin
                ts_r <= ts_r;
            end
        end
    end

    assign block_ts = ts_r;
`endif

endmodule

// File: tb/tb_photon_deadlock_monitor.sv
// Directed bench for photon_deadlock_monitor: two instances (HOLD=1 with group term, HOLD=8 without).
module tb_photon_deadlock_monitor;

    logic clock = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clock = ~clock;

    // Instance A: N_AXIS=4, N_INST=3, HOLD_CYCLES=1, CNT_W=4
    logic [3:0] a_axis;
    logic [2:0] a_idle, a_blk;
    logic       a_clear, a_block, a_sticky;
    logic [2:0] a_src;
    logic [3:0] a_events;
    // Instance B: N_AXIS=4, N_INST=0, HOLD_CYCLES=8, CNT_W=16
    logic [3:0]  b_axis;
    logic        b_idle, b_blk;
    logic        b_clear, b_block, b_sticky;
    logic [2:0]  b_src;
    logic [15:0] b_events;
`ifdef DEADLOCK_MON_TIMESTAMP_EN
    logic [31:0] a_ts, b_ts;
`endif

    photon_deadlock_monitor #(.N_AXIS(4), .N_INST(3), .HOLD_CYCLES(1), .CNT_W(4)) dut_a (
        .clock           (clock),
        .reset           (reset),
        .axis_block_sigs (a_axis),
        .inst_idle_sigs  (a_idle),
        .inst_block_sigs (a_blk),
        .clear           (a_clear),
        .block           (a_block),
        .block_sticky    (a_sticky),
        .block_src       (a_src),
        .block_events    (a_events)
`ifdef DEADLOCK_MON_TIMESTAMP_EN
        ,
        .block_ts        (a_ts)
`endif
    );

    photon_deadlock_monitor #(.N_AXIS(4), .N_INST(0), .HOLD_CYCLES(8), .CNT_W(16)) dut_b (
        .clock           (clock),
        .reset           (reset),
        .axis_block_sigs (b_axis),
        .inst_idle_sigs  (b_idle),
        .inst_block_sigs (b_blk),
        .clear           (b_clear),
        .block           (b_block),
        .block_sticky    (b_sticky),
        .block_src       (b_src),
        .block_events    (b_events)
`ifdef DEADLOCK_MON_TIMESTAMP_EN
        ,
        .block_ts        (b_ts)
`endif
    );

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        reset   = 1'b1;
        a_axis  = 4'd0; a_idle = 3'd0; a_blk = 3'd0; a_clear = 1'b0;
        b_axis  = 4'd0; b_idle = 1'bx; b_blk = 1'bx; b_clear = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        total++;
        if ({a_block, a_sticky, a_src, a_events} !== 9'd0) begin
            bad++; $display("FAIL reset_a: got %b want 0", {a_block, a_sticky, a_src, a_events});
        end
        total++;
        if ({b_block, b_sticky, b_src, b_events} !== 21'd0) begin
            bad++; $display("FAIL reset_b: got %b want 0", {b_block, b_sticky, b_src, b_events});
        end
    endtask

    task automatic test_hold1;
        a_axis = 4'b0100;
        for (int i = 1; i <= 3; i++) begin
            tick();
            total++;
            if (a_block !== 1'b1) begin
                bad++; $display("FAIL hold1_block cyc%0d: got %b want 1", i, a_block);
            end
        end
        total++;
        if (a_src !== 3'd2) begin bad++; $display("FAIL hold1_src: got %0d want 2", a_src); end
        total++;
        if (a_events !== 4'd1) begin bad++; $display("FAIL hold1_events: got %0d want 1", a_events); end
        total++;
        if (a_sticky !== 1'b1) begin bad++; $display("FAIL hold1_sticky: got %b want 1", a_sticky); end
        a_axis = 4'd0;
        tick();
        total++;
        if (a_block !== 1'b0) begin bad++; $display("FAIL hold1_fall: got %b want 0", a_block); end
        total++;
        if (a_sticky !== 1'b1) begin bad++; $display("FAIL hold1_sticky_hold: got %b want 1", a_sticky); end
    endtask

    task automatic test_group;
        a_idle = 3'b101;
        a_blk  = 3'b010;
        tick();
        total++;
        if (a_block !== 1'b1) begin bad++; $display("FAIL group_block: got %b want 1", a_block); end
        total++;
        if (a_src !== 3'd4) begin bad++; $display("FAIL group_src: got %0d want 4", a_src); end
        total++;
        if (a_events !== 4'd2) begin bad++; $display("FAIL group_events: got %0d want 2", a_events); end
        a_idle = 3'b001;
        tick();
        total++;
        if (a_block !== 1'b0) begin bad++; $display("FAIL group_nohit: got %b want 0", a_block); end
        a_idle = 3'd0;
        a_blk  = 3'd0;
    endtask

    task automatic test_clear_entry;
        a_axis  = 4'b0001;
        a_clear = 1'b1;
        tick();
        a_clear = 1'b0;
        total++;
        if ({a_block, a_sticky, a_src, a_events} !== {1'b1, 1'b1, 3'd0, 4'd1}) begin
            bad++; $display("FAIL clear_entry: got blk=%b sticky=%b src=%0d ev=%0d want 1 1 0 1",
                            a_block, a_sticky, a_src, a_events);
        end
        a_clear = 1'b1;
        tick();
        a_clear = 1'b0;
        total++;
        if ({a_block, a_sticky, a_src, a_events} !== {1'b1, 1'b0, 3'd0, 4'd0}) begin
            bad++; $display("FAIL clear_while_blocked: got blk=%b sticky=%b src=%0d ev=%0d want 1 0 0 0",
                            a_block, a_sticky, a_src, a_events);
        end
        a_axis = 4'd0;
        tick();
    endtask

    task automatic test_saturate;
        for (int ep = 1; ep <= 20; ep++) begin
            a_axis = 4'b1000;
            tick();
            a_axis = 4'd0;
            tick();
            if (ep == 15) begin
                total++;
                if (a_events !== 4'd15) begin bad++; $display("FAIL sat_ep15: got %0d want 15", a_events); end
            end
        end
        total++;
        if (a_events !== 4'd15) begin bad++; $display("FAIL sat_ep20: got %0d want 15", a_events); end
        total++;
        if (a_src !== 3'd3) begin bad++; $display("FAIL sat_src: got %0d want 3", a_src); end
        a_clear = 1'b1;
        tick();
        a_clear = 1'b0;
        total++;
        if ({a_sticky, a_src, a_events} !== 8'd0) begin
            bad++; $display("FAIL sat_clear: got sticky=%b src=%0d ev=%0d want 0", a_sticky, a_src, a_events);
        end
    endtask

    task automatic test_hold8;
        b_axis = 4'b0010;
        for (int i = 1; i <= 7; i++) begin
            tick();
            total++;
            if (b_block !== 1'b0) begin bad++; $display("FAIL hold8_short cyc%0d: got %b want 0", i, b_block); end
        end
        b_axis = 4'd0;
        tick();
        total++;
        if ({b_block, b_events} !== 17'd0) begin
            bad++; $display("FAIL hold8_short_end: got blk=%b ev=%0d want 0 0", b_block, b_events);
        end
        b_axis = 4'b0010;
        for (int i = 1; i <= 8; i++) begin
            tick();
            total++;
            if (b_block !== (i == 8)) begin
                bad++; $display("FAIL hold8_full cyc%0d: got %b want %b", i, b_block, (i == 8));
            end
        end
        total++;
        if (b_events !== 16'd1) begin bad++; $display("FAIL hold8_events: got %0d want 1", b_events); end
        total++;
        if (b_src !== 3'd1) begin bad++; $display("FAIL hold8_src: got %0d want 1", b_src); end
        b_axis = 4'd0;
        tick();
        total++;
        if (b_block !== 1'b0) begin bad++; $display("FAIL hold8_fall: got %b want 0", b_block); end
    endtask

    task automatic test_reset_mid_arming;
        b_axis = 4'b0100;
        repeat (5) tick();
        reset = 1'b1;
        tick();
        total++;
        if ({b_block, b_sticky, b_src, b_events} !== 21'd0) begin
            bad++; $display("FAIL rst_arm_b: got %b want 0", {b_block, b_sticky, b_src, b_events});
        end
        total++;
        if ({a_block, a_sticky, a_src, a_events} !== 9'd0) begin
            bad++; $display("FAIL rst_arm_a: got %b want 0", {a_block, a_sticky, a_src, a_events});
        end
        reset = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            total++;
            if (b_block !== (i == 8)) begin
                bad++; $display("FAIL rst_arm_fresh cyc%0d: got %b want %b", i, b_block, (i == 8));
            end
        end
        total++;
        if ({b_src, b_events} !== {3'd2, 16'd1}) begin
            bad++; $display("FAIL rst_arm_status: got src=%0d ev=%0d want 2 1", b_src, b_events);
        end
        b_axis = 4'd0;
        tick();
    endtask

`ifdef DEADLOCK_MON_TIMESTAMP_EN
    task automatic test_timestamp;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++;
        if (a_ts !== 32'd0) begin bad++; $display("FAIL ts_reset: got %0d want 0", a_ts); end
        repeat (100) tick();
        a_axis = 4'b0001;
        tick();
        total++;
        if (a_ts !== 32'd100) begin bad++; $display("FAIL ts_capture: got %0d want 100", a_ts); end
        a_axis  = 4'd0;
        a_clear = 1'b1;
        tick();
        a_clear = 1'b0;
        total++;
        if (a_ts !== 32'd0) begin bad++; $display("FAIL ts_clear: got %0d want 0", a_ts); end
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_hold1();
        test_group();
        test_clear_entry();
        test_saturate();
        test_hold8();
        test_reset_mid_arming();
`ifdef DEADLOCK_MON_TIMESTAMP_EN
        test_timestamp();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
